adc_channel_scheduler: RTL and testbench

Shares the on-board ADC128S022 serial ADC between up to N_REQ requesters, for example the line sensor, battery monitor and IR distance sensor.
- Round-robin arbiter picks one pending request at a time.
- Frame sequencer generates adc_sck, adc_cs_n and din from clk_50M, and deserialises dout.
- Each result is returned as a 12-bit value tagged with the requester index.
- Replaces free-running channel rotation with on-demand, arbitrated conversions.

---
 rtl/adc_channel_scheduler_pkg.sv | 31 +++
 rtl/adc_channel_scheduler_if.sv | 25 ++
 rtl/adc_channel_scheduler_arbiter.sv | 39 +++
 rtl/adc_channel_scheduler.sv | 157 +++++++++++++++
 tb/tb_adc_channel_scheduler.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_channel_scheduler_pkg.sv
// Shared types and frame constants for the ADC128S022 channel scheduler.
// The scheduler and its round-robin arbiter both import this package.
package adc_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_FRAME,
      S_GAP,
      S_DONE
   } sched_state_t;

   localparam int ADC_BITS  = 12;
   localparam int FRAME_SCK = 16;

   localparam logic [3:0] ADDR_FIRST_K = 4'd2;
   localparam logic [3:0] ADDR_LAST_K  = 4'd4;
   localparam logic [3:0] DATA_FIRST_K = 4'd4;
   localparam logic [3:0] DATA_LAST_K  = 4'd15;

   // Address bit carried on din during sck period k: ch[2] first, ch[0] last.
   function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] ch);
      logic bit_out;
      bit_out = 1'b0;
      if (k >= ADDR_FIRST_K && k <= ADDR_LAST_K) begin
         bit_out = ch[2'(ADDR_LAST_K - k)];
      end
      return bit_out;
   endfunction

endpackage

// File: rtl/adc_channel_scheduler_if.sv
// Requester-side bus of the ADC scheduler.
// Requests in, acks and tagged conversion results out.
interface adc_channel_scheduler_if #(
   parameter int N_REQ = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   req_valid;
   logic [3*N_REQ-1:0] req_ch;
   logic [N_REQ-1:0]   req_ack;
   logic               result_valid;
   logic [11:0]        result_data;
   logic [ID_W-1:0]    result_id;
   logic               busy;

   modport master (
      output req_valid, req_ch,
      input  req_ack, result_valid, result_data, result_id, busy
   );

   modport slave (
      input  req_valid, req_ch,
      output req_ack, result_valid, result_data, result_id, busy
   );
endinterface

// File: rtl/adc_channel_scheduler_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above the
// pointer, wrapping, and advances the pointer past each winner.
module adc_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   logic [ID_W-1:0] ptr;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         if (enable && !any && req[(int'(ptr) + off) % N_REQ]) begin
            any = 1'b1;
            grant[(int'(ptr) + off) % N_REQ] = 1'b1;
            idx = ID_W'((int'(ptr) + off) % N_REQ);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (any) begin
         ptr <= (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Arbitrates on-demand ADC128S022 conversions between requesters and runs
// the serial frames, adding a dummy address frame when the channel changes.
module adc_channel_scheduler
   import adc_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int SCK_DIV = 16,
   parameter int GAP_SCK = 1
) (
   input  logic clk_50M,
   input  logic reset,
   adc_channel_scheduler_if.slave bus,
   output logic adc_sck,
   output logic adc_cs_n,
   output logic din,
   input  logic dout
);

   localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int DIV_W   = $clog2(SCK_DIV);
   localparam int HALF    = SCK_DIV / 2;
   localparam int GAP_CYC = GAP_SCK * SCK_DIV;
   localparam int GAP_W   = $clog2(GAP_CYC + 1);

   sched_state_t         state;
   logic [DIV_W-1:0]     div_cnt;
   logic [3:0]           sck_k;
   logic [GAP_W-1:0]     gap_cnt;
   logic [2:0]           cur_ch;
   logic [2:0]           last_ch;
   logic                 last_ch_valid;
   logic                 second_pending;
   logic [ID_W-1:0]      cur_id;
   logic [ADC_BITS-1:0]  shift_reg;

   logic [N_REQ-1:0]     grant;
   logic [ID_W-1:0]      grant_idx;
   logic                 grant_any;
   logic [2:0]           grant_ch;

   adc_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arbiter (
      .clk    (clk_50M),
      .reset  (reset),
      .enable (state == S_IDLE),
      .req    (bus.req_valid),
      .grant  (grant),
      .idx    (grant_idx),
      .any    (grant_any)
   );

   always_comb begin
      grant_ch = bus.req_ch[3*grant_idx +: 3];
   end

   // Outputs are registered alongside the state; every frame starts with a
   // falling sck edge, and dout is captured on the edge that raises sck.
   always_ff @(posedge clk_50M) begin
      if (reset) begin
         state            <= S_IDLE;
         adc_sck          <= 1'b1;
         adc_cs_n         <= 1'b1;
         din              <= 1'b0;
         bus.req_ack      <= '0;
         bus.result_valid <= 1'b0;
         bus.result_data  <= '0;
         bus.result_id    <= '0;
         bus.busy         <= 1'b0;
         div_cnt          <= '0;
         sck_k            <= '0;
         gap_cnt          <= '0;
         cur_ch           <= '0;
         last_ch          <= '0;
         last_ch_valid    <= 1'b0;
         second_pending   <= 1'b0;
         cur_id           <= '0;
         shift_reg        <= '0;
      end else begin
         bus.req_ack      <= '0;
         bus.result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  bus.req_ack    <= grant;
                  cur_ch         <= grant_ch;
                  cur_id         <= grant_idx;
                  bus.busy       <= 1'b1;
                  second_pending <= !last_ch_valid || (grant_ch != last_ch);
                  state          <= S_GRANT;
               end
            end
            S_GRANT: begin
               state    <= S_FRAME;
               adc_cs_n <= 1'b0;
               adc_sck  <= 1'b0;
               din      <= addr_bit(4'd0, cur_ch);
               div_cnt  <= '0;
               sck_k    <= '0;
            end
            S_FRAME: begin
               if (div_cnt == DIV_W'(SCK_DIV - 1)) begin
                  div_cnt <= '0;
                  if (sck_k == 4'(FRAME_SCK - 1)) begin
                     state         <= S_GAP;
                     adc_cs_n      <= 1'b1;
                     adc_sck       <= 1'b1;
                     din           <= 1'b0;
                     gap_cnt       <= '0;
                     last_ch       <= cur_ch;
                     last_ch_valid <= 1'b1;
                  end else begin
                     sck_k   <= sck_k + 4'd1;
                     adc_sck <= 1'b0;
                     din     <= addr_bit(sck_k + 4'd1, cur_ch);
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
                  if (div_cnt == DIV_W'(HALF - 1)) begin
                     adc_sck <= 1'b1;
                     if (sck_k >= DATA_FIRST_K) begin
                        shift_reg <= {shift_reg[ADC_BITS-2:0], dout};
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                  if (second_pending) begin
                     second_pending <= 1'b0;
                     state          <= S_FRAME;
                     adc_cs_n       <= 1'b0;
                     adc_sck        <= 1'b0;
                     din            <= addr_bit(4'd0, cur_ch);
                     div_cnt        <= '0;
                     sck_k          <= '0;
                  end else begin
                     state            <= S_DONE;
                     bus.result_valid <= 1'b1;
                     bus.result_data  <= shift_reg;
                     bus.result_id    <= cur_id;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_DONE: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Self-checking bench: an ADC128S022 model plus a scoreboard of expected
// acks, results, frame counts and latencies for the channel scheduler.
module tb_adc_channel_scheduler;

   localparam int N_REQ   = 4;
   localparam int SCK_DIV = 16;
   localparam int GAP_SCK = 1;
   localparam int HALF    = SCK_DIV / 2;

   typedef struct {
      int          id;
      logic [2:0]  ch;
      logic [11:0] data;
      int          frames;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic adc_sck, adc_cs_n, din, dout;

   exp_t exp_q[$];
   int   total_checks = 0;
   int   bad_checks   = 0;
   int   cycle        = 0;
   int   ack_count    = 0;
   int   result_count = 0;
   int   ack_cycle    = 0;
   int   frames_seen  = 0;
   int   model_k      = -1;
   int   low_cycles   = 0;
   int   run_len      = 0;
   int   run_bad      = 0;
   int   high_run     = 0;
   int   idle_bad     = 0;
   logic in_frame     = 1'b0;
   logic seen_frame   = 1'b0;
   logic busy_due     = 1'b0;
   logic prev_cs      = 1'b1;
   logic prev_sck     = 1'b1;
   logic [15:0] cap   = '0;
   logic [2:0]  m_last_ch    = '0;
   logic        m_last_valid = 1'b0;

   adc_channel_scheduler_if #(.N_REQ(N_REQ)) bus ();

   adc_channel_scheduler #(
      .N_REQ   (N_REQ),
      .SCK_DIV (SCK_DIV),
      .GAP_SCK (GAP_SCK)
   ) dut (
      .clk_50M  (clk),
      .reset    (reset),
      .bus      (bus),
      .adc_sck  (adc_sck),
      .adc_cs_n (adc_cs_n),
      .din      (din),
      .dout     (dout)
   );

   always #10 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, actual, expected);
      end
   endtask

   // Expected frame count comes from the bench's own record of the last channel sent.
   task automatic push_expected(input int id, input logic [2:0] ch, input logic [11:0] data);
      exp_t e;
      e.id     = id;
      e.ch     = ch;
      e.data   = data;
      e.frames = (!m_last_valid || ch != m_last_ch) ? 2 : 1;
      m_last_ch    = ch;
      m_last_valid = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic wait_acks(input int target, input string tag);
      int n = 0;
      while (ack_count < target && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (ack_count < target) check_output(tag, 32'(ack_count), 32'(target));
   endtask

   task automatic wait_results(input int target, input string tag);
      int n = 0;
      while (result_count < target && n < 4000) begin
         @(posedge clk); #1;
         n++;
      end
      if (result_count < target) check_output(tag, 32'(result_count), 32'(target));
   endtask

   task automatic apply_stimulus(input int id, input logic [2:0] ch, input logic [11:0] data);
      int acks = ack_count + 1;
      int res  = result_count + 1;
      push_expected(id, ch, data);
      @(posedge clk); #1;
      bus.req_ch[3*id +: 3] = ch;
      bus.req_valid[id]     = 1'b1;
      wait_acks(acks, "ack_timeout");
      bus.req_valid[id] = 1'b0;
      wait_results(res, "result_timeout");
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      m_last_valid = 1'b0;
   endtask

   // Monitor, ADC model and scoreboard, all sampled away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      logic [11:0] w;
      cycle++;
      if (reset) begin
         in_frame = 1'b0;
         model_k  = -1;
         busy_due = 1'b0;
      end else begin
         if (busy_due) begin
            check_output("busy_after_done", bus.busy, 0);
            busy_due = 1'b0;
         end
         if (bus.req_ack != '0) begin
            ack_count++;
            ack_cycle   = cycle;
            frames_seen = 0;
            if (exp_q.size() == 0) check_output("unexpected_ack", 32'(bus.req_ack), 0);
            else begin
               check_output("ack_onehot", 32'(bus.req_ack), 32'(1) << exp_q[0].id);
               check_output("busy_at_ack", bus.busy, 1);
            end
         end
         if (bus.result_valid) begin
            if (exp_q.size() == 0) check_output("unexpected_result", 1, 0);
            else begin
               e = exp_q.pop_front();
               result_count++;
               check_output("result_id", 32'(bus.result_id), 32'(e.id));
               check_output("result_data", 32'(bus.result_data), 32'(e.data));
               check_output("frame_count", 32'(frames_seen), 32'(e.frames));
               check_output("latency", 32'(cycle - ack_cycle), 32'(1 + (16 + GAP_SCK) * SCK_DIV * e.frames));
               check_output("busy_at_done", bus.busy, 1);
               busy_due = 1'b1;
            end
         end
         if (!adc_cs_n && prev_cs) begin
            if (seen_frame) check_output("cs_high_time", 32'(high_run >= SCK_DIV), 1);
            in_frame   = 1'b1;
            seen_frame = 1'b1;
            frames_seen++;
            low_cycles = 0;
            run_len    = 0;
            run_bad    = 0;
            cap        = '0;
            model_k    = -1;
            prev_sck   = 1'b1;
         end
         if (!adc_cs_n && in_frame) begin
            low_cycles++;
            if (adc_sck != prev_sck) begin
               if (run_len != 0 && run_len != HALF) run_bad++;
               run_len = 1;
               if (!adc_sck) begin
                  model_k++;
                  if (model_k >= 4 && exp_q.size() > 0) begin
                     w    = exp_q[0].data;
                     dout = w[15 - model_k];
                  end else begin
                     dout = 1'($urandom_range(0, 1));
                  end
               end else begin
                  cap = {cap[14:0], din};
               end
            end else begin
               run_len++;
            end
         end
         if (adc_cs_n && !prev_cs && in_frame) begin
            in_frame = 1'b0;
            model_k  = -1;
            if (run_len != HALF) run_bad++;
            check_output("frame_len", 32'(low_cycles), 32'(16 * SCK_DIV));
            check_output("sck_shape", 32'(run_bad), 0);
            if (exp_q.size() > 0) check_output("din_bits", 32'(cap), 32'({2'b00, exp_q[0].ch, 11'b0}));
            high_run = 0;
         end
         if (adc_cs_n) begin
            high_run++;
            if (adc_sck !== 1'b1 || din !== 1'b0) idle_bad++;
         end
      end
      prev_cs  = adc_cs_n;
      prev_sck = adc_sck;
   end

   initial begin
      int acks, res, n;
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_ch    = '0;
      dout          = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_sck", adc_sck, 1);
      check_output("rst_cs_n", adc_cs_n, 1);
      check_output("rst_din", din, 0);
      check_output("rst_ack", 32'(bus.req_ack), 0);
      check_output("rst_result", {bus.result_valid, bus.result_data, bus.result_id, bus.busy}, 0);
      @(posedge clk); #1 reset = 1'b0;

      // Fresh channel needs an address frame; a repeated channel does not.
      apply_stimulus(1, 3'd3, 12'hA5C);
      apply_stimulus(1, 3'd3, 12'h123);

      // Two requesters held high must alternate.
      do_reset();
      acks = ack_count + 4;
      res  = result_count + 4;
      push_expected(0, 3'd1, 12'h111);
      push_expected(2, 3'd5, 12'h222);
      push_expected(0, 3'd1, 12'h333);
      push_expected(2, 3'd5, 12'h444);
      bus.req_ch[2:0]  = 3'd1;
      bus.req_ch[8:6]  = 3'd5;
      bus.req_valid    = 4'b0101;
      wait_acks(acks, "rr_ack_timeout");
      bus.req_valid = '0;
      wait_results(res, "rr_result_timeout");

      apply_stimulus(3, 3'd7, 12'h5A5);
      apply_stimulus(3, 3'd0, 12'h0F0);

      // Reset in the middle of a frame drops the request and forgets last_ch.
      acks = ack_count + 1;
      push_expected(1, 3'd2, 12'h777);
      @(posedge clk); #1;
      bus.req_ch[5:3]  = 3'd2;
      bus.req_valid[1] = 1'b1;
      wait_acks(acks, "abort_ack_timeout");
      bus.req_valid[1] = 1'b0;
      n = 0;
      while (model_k != 9 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (model_k != 9) check_output("abort_k9_timeout", 32'(model_k), 9);
      reset = 1'b1;
      void'(exp_q.pop_front());
      m_last_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("abort_cs_n", adc_cs_n, 1);
      check_output("abort_sck", adc_sck, 1);
      check_output("abort_din", din, 0);
      check_output("abort_busy", bus.busy, 0);
      check_output("abort_rvalid", bus.result_valid, 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (600) @(posedge clk);
      check_output("abort_no_ack", 32'(ack_count), 32'(acks));
      apply_stimulus(1, 3'd2, 12'h3C3);

      // Saturated data words.
      apply_stimulus(0, 3'd4, 12'hFFF);
      apply_stimulus(0, 3'd4, 12'h000);

      repeat (20) @(posedge clk);
      check_output("idle_pins", 32'(idle_bad), 0);
      check_output("queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
